pool_mem_arbiter: RTL and testbench

- Arbitrates the single intermediate-layer memory port between up to NUM_REQ layer engines (pooling loader, pooling writer, conv loader, ...).
- Each engine raises a request carrying read/write, start address and word count.
- The arbiter grants one engine round-robin and issues its transaction to the memory controller.
- It waits for the memory controller's op-done, then returns a one-cycle done pulse to the granted engine.

---
 rtl/pool_mem_arbiter.sv | 110 +++++++++++
 tb/tb_pool_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_mem_arbiter.sv
// rtl/pool_mem_arbiter.sv - round-robin arbiter for the shared intermediate-layer memory port
module pool_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          mem_en,
    output logic                          mem_rw,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [LEN_WIDTH-1:0]          mem_len,
    input  logic                          mem_done,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic [LEN_WIDTH-1:0] pick_len;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        return IDX_W'(j);
    endfunction

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[wrap_idx(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = wrap_idx(rr_ptr, k);
            end
        end
    end

    assign pick_len = req_len[pick*LEN_WIDTH +: LEN_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            req_done <= '0;
            mem_en   <= 1'b0;
            mem_rw   <= 1'b0;
            mem_addr <= '0;
            mem_len  <= '0;
            busy     <= 1'b0;
            rr_ptr   <= '0;
            winner   <= '0;
        end else begin
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        winner   <= pick;
                        gnt      <= ONE << pick;
                        mem_rw   <= req_rw[pick];
                        mem_addr <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_len  <= pick_len;
                        busy     <= 1'b1;
                        state    <= (pick_len != '0) ? ISSUE : RELEASE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b1;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        req_done <= gnt;
                        gnt      <= '0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    // A zero-length grant arrives here with gnt still set: pulse done first, then leave.
                    if (gnt != '0) begin
                        req_done <= gnt;
                        gnt      <= '0;
                    end else begin
                        req_done <= '0;
                        rr_ptr   <= wrap_idx(winner, 1);
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_mem_arbiter.sv
// tb/tb_pool_mem_arbiter.sv - scoreboard bench for pool_mem_arbiter
module tb_pool_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_rw = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    req_done;
    logic            mem_en;
    logic            mem_rw;
    logic [AW-1:0]   mem_addr;
    logic [LW-1:0]   mem_len;
    logic            mem_done;
    logic            busy;

    logic mem_done_a = 1'b0;
    logic mem_done_s = 1'b0;
    assign mem_done = mem_done_a | mem_done_s;

    int checks = 0;
    int errors = 0;
    int mem_lat = 3;
    bit mem_auto = 1'b1;
    int remaining[N];

    typedef struct {
        logic [N-1:0]  g;
        logic          rw;
        logic [AW-1:0] a;
        logic [LW-1:0] l;
    } iss_t;
    typedef struct {
        logic [N-1:0] g;
        bit           zl;
    } done_t;

    iss_t  exp_iss[$];
    done_t exp_done[$];

    pool_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_len(req_len), .gnt(gnt), .req_done(req_done), .mem_en(mem_en),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_done(mem_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
        end
    endtask

    task automatic set_eng(input int i, input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_rw[i]           = rw;
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
    endtask

    task automatic expect_txn(input int i);
        iss_t         e;
        done_t        d;
        logic [N-1:0] one;
        one  = 1;
        e.g  = one << i;
        e.rw = req_rw[i];
        e.a  = req_addr[i*AW +: AW];
        e.l  = req_len[i*LW +: LW];
        if (e.l != '0) exp_iss.push_back(e);
        d.g  = e.g;
        d.zl = (e.l == '0);
        exp_done.push_back(d);
    endtask

    // Engine behaviour: keep requesting until the requested number of grants is served.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_done[i]) begin
                if (remaining[i] > 1) remaining[i]--;
                else begin
                    remaining[i] = 0;
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_iss.size() != 0 || exp_done.size() != 0 || busy || req != '0) && c < budget) begin
            step();
            c++;
        end
        chk_eq("drain_within_budget", (c < budget), 1);
    endtask

    // Memory controller model
    initial begin
        forever begin
            @(negedge clk);
            if (mem_en && mem_auto) begin
                repeat (mem_lat) @(posedge clk);
                #1 mem_done_a = 1'b1;
                @(posedge clk);
                #1 mem_done_a = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        logic [N-1:0] prev_gnt;
        logic         prev_md;
        iss_t         e;
        done_t        d;
        prev_gnt = '0;
        prev_md  = 1'b0;
        forever begin
            @(negedge clk);
            chk_eq("gnt_onehot", ($countones(gnt) <= 1), 1);
            if (mem_en) begin
                if (exp_iss.size() == 0) chk_eq("mem_en_unexpected", mem_en, 0);
                else begin
                    e = exp_iss.pop_front();
                    chk_eq("mem_en_gnt", gnt, e.g);
                    chk_eq("mem_en_prev_gnt", prev_gnt, e.g);
                    chk_eq("mem_rw", mem_rw, e.rw);
                    chk_eq("mem_addr", mem_addr, e.a);
                    chk_eq("mem_len", mem_len, e.l);
                end
            end
            if (req_done != '0) begin
                if (exp_done.size() == 0) chk_eq("req_done_unexpected", req_done, 0);
                else begin
                    d = exp_done.pop_front();
                    chk_eq("req_done_engine", req_done, d.g);
                    chk_eq("done_prev_gnt", prev_gnt, d.g);
                    chk_eq("done_gnt_cleared", gnt, 0);
                    if (!d.zl) chk_eq("done_after_mem_done", prev_md, 1);
                end
            end
            prev_gnt = gnt;
            prev_md  = mem_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) remaining[i] = 0;
        set_eng(0, 1'b1, 20'h0F0F0, 16'd7);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_eq("rst_gnt", gnt, 0);
        chk_eq("rst_req_done", req_done, 0);
        chk_eq("rst_mem_en", mem_en, 0);
        chk_eq("rst_mem_rw", mem_rw, 0);
        chk_eq("rst_mem_addr", mem_addr, 0);
        chk_eq("rst_mem_len", mem_len, 0);
        chk_eq("rst_busy", busy, 0);
        reset = 1'b0;

        // Contention: all three held, order 0,1,2,0
        mem_lat = 3;
        set_eng(0, 1'b1, 20'h01000, 16'd8);
        set_eng(1, 1'b0, 20'h02000, 16'd4);
        set_eng(2, 1'b1, 20'h03000, 16'd2);
        expect_txn(0); expect_txn(1); expect_txn(2);
        set_eng(0, 1'b0, 20'h01800, 16'd9);
        expect_txn(0);
        set_eng(0, 1'b1, 20'h01000, 16'd8);
        remaining[0] = 2; remaining[1] = 1; remaining[2] = 1;
        req = 3'b111;
        step();
        set_eng(0, 1'b0, 20'h01800, 16'd9);
        drain(300);

        // Zero length on engine 1
        set_eng(1, 1'b1, 20'h00100, 16'd0);
        expect_txn(1);
        remaining[1] = 1; req[1] = 1'b1;
        step();
        chk_eq("zl_gnt", gnt, 3'b010);
        chk_eq("zl_no_mem_en", mem_en, 0);
        step();
        chk_eq("zl_done", req_done, 3'b010);
        step();
        chk_eq("zl_busy_low", busy, 0);
        drain(20);

        // Single request with latency checks
        mem_lat = 10;
        set_eng(0, 1'b1, 20'h00400, 16'd1024);
        expect_txn(0);
        remaining[0] = 1; req[0] = 1'b1;
        step();
        chk_eq("single_gnt_t1", gnt, 3'b001);
        chk_eq("single_no_en_t1", mem_en, 0);
        step();
        chk_eq("single_en_t2", mem_en, 1);
        drain(100);

        // Robustness: drop req and change addr during WAIT
        mem_lat = 6;
        set_eng(2, 1'b0, 20'h0ABCD, 16'd5);
        expect_txn(2);
        remaining[2] = 1; req[2] = 1'b1;
        step(); step();
        chk_eq("rob_mem_en", mem_en, 1);
        step();
        req[2] = 1'b0;
        set_eng(2, 1'b1, 20'h12345, 16'd77);
        step(); step();
        chk_eq("rob_addr_hold", mem_addr, 20'h0ABCD);
        chk_eq("rob_len_hold", mem_len, 16'd5);
        chk_eq("rob_gnt_hold", gnt, 3'b100);
        drain(50);

        // Fairness: engines 0 and 2 keep requesting
        mem_lat = 3;
        set_eng(0, 1'b1, 20'h00010, 16'd1);
        set_eng(2, 1'b0, 20'h00020, 16'd2);
        expect_txn(0); expect_txn(2); expect_txn(0); expect_txn(2);
        remaining[0] = 2; remaining[2] = 2;
        req = 3'b101;
        drain(200);

        // Spurious mem_done in IDLE
        @(posedge clk); #1 mem_done_s = 1'b1;
        @(posedge clk); #1 mem_done_s = 1'b0;
        step();
        chk_eq("spur_gnt", gnt, 0);
        chk_eq("spur_busy", busy, 0);
        chk_eq("spur_req_done", req_done, 0);
        step();
        chk_eq("spur_busy2", busy, 0);

        // Move rr_ptr to 2, then reset during WAIT
        mem_lat = 2;
        set_eng(1, 1'b1, 20'h00777, 16'd4);
        expect_txn(1);
        remaining[1] = 1; req[1] = 1'b1;
        drain(50);
        mem_auto = 1'b0;
        set_eng(1, 1'b1, 20'h22222, 16'd8);
        expect_txn(1);
        remaining[1] = 1; req[1] = 1'b1;
        step(); step();
        chk_eq("rst_wait_mem_en", mem_en, 1);
        step();
        reset = 1'b1;
        req[1] = 1'b0; remaining[1] = 0;
        step();
        chk_eq("rstw_gnt", gnt, 0);
        chk_eq("rstw_busy", busy, 0);
        chk_eq("rstw_mem_rw", mem_rw, 0);
        chk_eq("rstw_mem_addr", mem_addr, 0);
        chk_eq("rstw_mem_len", mem_len, 0);
        chk_eq("rstw_req_done", req_done, 0);
        reset = 1'b0;
        exp_done.delete();
        repeat (4) step();
        mem_auto = 1'b1;

        // rr_ptr back at 0: engine 0 wins over engine 2
        set_eng(0, 1'b0, 20'h00A00, 16'd3);
        set_eng(2, 1'b1, 20'h00C00, 16'd3);
        expect_txn(0); expect_txn(2);
        remaining[0] = 1; remaining[2] = 1;
        req = 3'b101;
        step();
        chk_eq("rr_after_reset", gnt, 3'b001);
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
